imm_extend_seq: RTL
===================

Name: imm_extend_seq

Overview:
- Sequential, parametrised immediate-extension unit for the processor decode path.
- Successor to the combinational 12-bit extender. Adds selectable immediate modes (ARM data-processing rotated imm8, zero-extended imm12, branch imm24), a rotator that rotates a bounded number of bits per cycle, a shifter carry output, and valid/ready handshakes on input and output.
- Sits between instruction decode and the ALU operand-B mux.

Parameters:
- WIDTH, 32, output datapath width. Must be even and ≥ 32.
- ROT_PER_CYCLE, 2, maximum rotate-right distance applied per ROTATE cycle. Legal values: 1, 2, 4, 8, 16.

Ports:
- CLK  in  1  rising-edge clock
- RESETn  in  1  asynchronous active-low reset
- InValid  in  1  request valid
- InReady  out  1  unit can accept a request
- ImmSrc  in  2  mode: 00 rotated imm8, 01 zext imm12, 10 branch imm24, 11 reserved
- Instr  in  24  instruction bits [23:0]
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- ExtImm  out  WIDTH  extended immediate
- CarryOut  out  1  shifter carry: ExtImm[WIDTH-1] if rotate amount ≠ 0, else 0
- CarryValid  out  1  1 when the rotate amount ≠ 0 (mode 00 only)
- ImmErr  out  1  reserved mode requested

Behaviour:
- Reset (RESETn low, async, any state): state = IDLE; ExtImm = 0; OutValid, CarryOut, CarryValid, ImmErr = 0; InReady = 0 while RESETn is low. Deassertion takes effect on the next CLK edge.
- States: IDLE, ROTATE, DONE. InReady = 1 only in IDLE. OutValid = 1 only in DONE.
- IDLE: a request is accepted on a CLK edge with InValid & InReady. Captured values depend on ImmSrc:
  - 00: data = zext(Instr[7:0]); rem = 2*Instr[11:8] (0..30). rem = 0 → DONE; else → ROTATE. CarryValid = (rem ≠ 0).
  - 01: data = zext(Instr[11:0]) → DONE.
  - 10: data = sext(Instr[23:0]) << 2 → DONE.
  - 11: data = 0, ImmErr = 1 → DONE.
  - Instr[23:12] is ignored for modes 00/01. Instr[11:8] is ignored for mode 01.
- ROTATE, each cycle: step = min(rem, ROT_PER_CYCLE); data = data rotated right by step within WIDTH; rem = rem − step. If the new rem = 0 → DONE.
- Latency from the accept edge to OutValid high:
  - rem = 0 or modes 01/10/11: 1 cycle.
  - otherwise: 1 + ceil(rem/ROT_PER_CYCLE) cycles.
- DONE: ExtImm, CarryOut, CarryValid and ImmErr are stable and held while OutReady = 0. On OutValid & OutReady → IDLE.
- No accept in the same cycle as a DONE handoff: at most one request every 2 cycles.
- Outputs are registered; ExtImm holds its last value in IDLE/ROTATE. CarryValid and ImmErr clear on accept of the next request.
- InValid in ROTATE/DONE is ignored; the requester must hold its request until InReady.
- Reset in the middle of ROTATE aborts the operation. There is no OutValid pulse; after release the unit is in IDLE with InReady = 1.

Test Plan:
- ImmSrc=00, Instr[11:0]=0x0FF → ExtImm=0x000000FF, CarryValid=0, CarryOut=0, OutValid 1 cycle after accept.
- ImmSrc=00, Instr[11:0]=0x2FF, ROT_PER_CYCLE=2 → ExtImm=0xF000000F, CarryValid=1, CarryOut=1, OutValid 3 cycles after accept. Repeat with ROT_PER_CYCLE=4 → same value, 2 cycles.
- ImmSrc=00, Instr[11:0]=0x4FF → 0xFF000000, CarryOut=1. Instr[11:0]=0xF01 (rem 30) → 0x00000004, CarryOut=0, 16 cycles at ROT_PER_CYCLE=2.
- ImmSrc=01, Instr=0xFFFABC → 0x00000ABC. ImmSrc=10, Instr=0xFFFFFE → 0xFFFFFFF8. ImmSrc=10, Instr=0x000001 → 0x00000004. ImmSrc=11 → ExtImm=0, ImmErr=1.
- Backpressure: OutReady=0 for 5 cycles in DONE → ExtImm, OutValid and CarryOut held and InReady=0; OutReady=1 → IDLE next edge, InReady=1.
- RESETn pulsed low mid-ROTATE of 0xF01 → outputs clear immediately with no OutValid. The next request 0x0FF completes normally with 0x000000FF.

Source files
------------

// File: rtl/imm_extend_seq_if.sv
// Request/response bundle for the sequential immediate extender.
// The decode stage is the master: it raises requests and consumes results.
// The extender is the slave.
interface imm_extend_seq_if #(
  parameter int WIDTH = 32
) ();

  // Request side
  logic             InValid;
  logic             InReady;
  logic [1:0]       ImmSrc;
  logic [23:0]      Instr;

  // Result side
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ExtImm;
  logic             CarryOut;
  logic             CarryValid;
  logic             ImmErr;

  modport master (
    output InValid, ImmSrc, Instr, OutReady,
    input  InReady, OutValid, ExtImm, CarryOut, CarryValid, ImmErr
  );

  modport slave (
    input  InValid, ImmSrc, Instr, OutReady,
    output InReady, OutValid, ExtImm, CarryOut, CarryValid, ImmErr
  );

endinterface

// File: rtl/imm_extend_seq.sv
// Sequential immediate extender for the decode -> ALU operand-B path.
// Modes: 00 ARM rotated imm8, 01 zero-extended imm12, 10 branch imm24
// (sign-extended, word-scaled), 11 reserved (flags ImmErr).
// The rotated-imm8 mode rotates at most ROT_PER_CYCLE bits per cycle, so
// wide rotations take several cycles; other modes finish in one.
module imm_extend_seq #(
  parameter int WIDTH         = 32,
  parameter int ROT_PER_CYCLE = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  imm_extend_seq_if.slave   bus
);

  // Elaboration-time legality checks on the parameters.
  if ((WIDTH < 32) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("imm_extend_seq: WIDTH must be even and >= 32");
  end
  if (!((ROT_PER_CYCLE == 1) || (ROT_PER_CYCLE == 2) || (ROT_PER_CYCLE == 4) ||
        (ROT_PER_CYCLE == 8) || (ROT_PER_CYCLE == 16))) begin : g_bad_rot
    $error("imm_extend_seq: ROT_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Remaining rotate distance is 2*rot4, at most 30, so five bits suffice.
  localparam int             REM_W    = 5;
  localparam logic [REM_W-1:0] ROT_STEP = REM_W'(ROT_PER_CYCLE);

  localparam logic [1:0] MODE_ROT8  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Rotate right within WIDTH by a small distance.
  function automatic logic [WIDTH-1:0] rot_right(
    input logic [WIDTH-1:0] d,
    input logic [REM_W-1:0] amt
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d} >> amt;
    return dbl[WIDTH-1:0];
  endfunction

  // Sign-extend the 24-bit branch offset and scale it to a byte offset.
  function automatic logic [WIDTH-1:0] ext_branch(input logic [23:0] off);
    logic signed [WIDTH-1:0] wide_s;
    wide_s = {{(WIDTH-24){off[23]}}, off};
    return wide_s <<< 2;
  endfunction

  // Zero-extend a 12-bit field.
  function automatic logic [WIDTH-1:0] ext_zero12(input logic [11:0] f);
    return {{(WIDTH-12){1'b0}}, f};
  endfunction

  // Zero-extend an 8-bit field.
  function automatic logic [WIDTH-1:0] ext_zero8(input logic [7:0] f);
    return {{(WIDTH-8){1'b0}}, f};
  endfunction

  state_t           state, next_state;

  // Working rotator contents and remaining distance.
  logic [WIDTH-1:0] data_p0;
  logic [REM_W-1:0] rem_p0;

  // Registered outputs.
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] ext_imm;
  logic             carry_out;
  logic             carry_valid;
  logic             imm_err;

  // Decoded capture values and one rotator step.
  logic             accept;
  logic             handoff;
  logic [WIDTH-1:0] cap_data;
  logic [REM_W-1:0] cap_rem;
  logic             cap_err;
  logic [REM_W-1:0] step;
  logic [WIDTH-1:0] rot_data;
  logic [REM_W-1:0] rot_rem;

  assign accept  = bus.InValid & in_ready;
  assign handoff = out_valid & bus.OutReady;

  // Decode the incoming instruction into an initial value and rotate distance.
  always_comb begin
    cap_data = '0;
    cap_rem  = '0;
    cap_err  = 1'b0;
    case (bus.ImmSrc)
      MODE_ROT8: begin
        cap_data = ext_zero8(bus.Instr[7:0]);
        cap_rem  = {bus.Instr[11:8], 1'b0};
      end
      MODE_ZEXT: begin
        cap_data = ext_zero12(bus.Instr[11:0]);
      end
      MODE_BRANCH: begin
        cap_data = ext_branch(bus.Instr);
      end
      default: begin
        cap_err = 1'b1;
      end
    endcase
  end

  // One rotator step: clip the distance to the per-cycle limit.
  always_comb begin
    step     = (rem_p0 < ROT_STEP) ? rem_p0 : ROT_STEP;
    rot_data = rot_right(data_p0, step);
    rot_rem  = rem_p0 - step;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (cap_rem == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        if (rot_rem == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (handoff) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the upcoming state, so InReady
  // stays low through reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Datapath: capture on accept, rotate while busy, publish the result on
  // entry to DONE. ExtImm/CarryOut keep their old value until then.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      data_p0     <= '0;
      rem_p0      <= '0;
      ext_imm     <= '0;
      carry_out   <= 1'b0;
      carry_valid <= 1'b0;
      imm_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_p0     <= cap_data;
            rem_p0      <= cap_rem;
            carry_valid <= (cap_rem != '0);
            imm_err     <= cap_err;
            if (cap_rem == '0) begin
              ext_imm   <= cap_data;
              carry_out <= 1'b0;
            end
          end
        end
        ROTATE: begin
          data_p0 <= rot_data;
          rem_p0  <= rot_rem;
          if (rot_rem == '0) begin
            ext_imm   <= rot_data;
            carry_out <= rot_data[WIDTH-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.InReady    = in_ready;
  assign bus.OutValid   = out_valid;
  assign bus.ExtImm     = ext_imm;
  assign bus.CarryOut   = carry_out;
  assign bus.CarryValid = carry_valid;
  assign bus.ImmErr     = imm_err;

endmodule
